flush_ctrl: RTL

FLUSH_CTRL -- requirements
Module: flush_ctrl

---
 rtl/flush_ctrl_pkg.sv | 33 +++
 rtl/flush_ctrl_stats.sv | 30 +++
 rtl/flush_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/flush_ctrl_pkg.sv
// Shared types and constants for the commit-stage flush/redirect controller.
// Used by flush_ctrl and flush_ctrl_stats.
package flush_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFlush    = 2'd1,
        StRedirect = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CauseNone = 2'b00,
        CauseExc  = 2'b01,
        CauseInt  = 2'b10,
        CauseEret = 2'b11
    } cause_t;

    // Exception/interrupt entry point with BEV=1.
    localparam logic [31:0] DefaultExcVector = 32'hbfc00380;

    // Exception beats interrupt beats eret when strobes coincide.
    function automatic cause_t pick_cause(input logic exc, input logic intr, input logic eret);
        if (exc) begin
            return CauseExc;
        end else if (intr) begin
            return CauseInt;
        end else if (eret) begin
            return CauseEret;
        end
        return CauseNone;
    endfunction

endpackage

// File: rtl/flush_ctrl_stats.sv
// Per-cause counters of accepted flush events; 16-bit, wrap on overflow.
// Only instantiated by flush_ctrl when FLUSH_CTRL_STATS_EN is defined.
module flush_ctrl_stats
    import flush_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        accept,
    input  cause_t      cause,
    output logic [15:0] exc_count,
    output logic [15:0] int_count,
    output logic [15:0] eret_count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_count  <= 16'h0000;
            int_count  <= 16'h0000;
            eret_count <= 16'h0000;
        end else if (accept) begin
            case (cause)
                CauseExc:  exc_count  <= exc_count + 16'h0001;
                CauseInt:  int_count  <= int_count + 16'h0001;
                CauseEret: eret_count <= eret_count + 16'h0001;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/flush_ctrl.sv
// Commit-stage flush/redirect controller: flushes the pipe on exception/interrupt/eret,
// then offers the redirect PC to fetch. Optional counters under FLUSH_CTRL_STATS_EN.
module flush_ctrl
    import flush_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = DefaultExcVector,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic        excep_cmt,
    input  logic        int_cmt,
    input  logic        eret_cmt,
    input  logic [31:0] epc_value,
    input  logic        redirect_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [3:0]  flush,
    output logic        commit_block,
    output logic [1:0]  event_cause
`ifdef FLUSH_CTRL_STATS_EN
    ,
    output logic [15:0] exc_count,
    output logic [15:0] int_count,
    output logic [15:0] eret_count
`endif
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..15");
    end

    state_t      state_q;
    logic [3:0]  cnt_q;
    cause_t      cause_q;
    logic [31:0] pc_q;
    logic [3:0]  flush_q;
    logic        valid_q;
    logic        block_q;

    cause_t      ev_cause;
    logic        accept;

    always_comb begin
        ev_cause = pick_cause(excep_cmt, int_cmt, eret_cmt);
        accept   = (state_q == StIdle) && wb_valid && (ev_cause != CauseNone);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            cause_q <= CauseNone;
            pc_q    <= 32'h0000_0000;
            flush_q <= 4'b0000;
            valid_q <= 1'b0;
            block_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StFlush;
                        cnt_q   <= 4'(FLUSH_CYCLES);
                        cause_q <= ev_cause;
                        pc_q    <= (ev_cause == CauseEret) ? epc_value : EXC_VECTOR;
                        flush_q <= 4'b1111;
                        block_q <= 1'b1;
                    end
                end
                StFlush: begin
                    // Counter holds the flush cycles still to go, including this one.
                    if (cnt_q == 4'd1) begin
                        state_q <= StRedirect;
                        cnt_q   <= 4'd0;
                        flush_q <= 4'b0000;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRedirect: begin
                    if (redirect_ready) begin
                        state_q <= StIdle;
                        cause_q <= CauseNone;
                        valid_q <= 1'b0;
                        block_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign redirect_valid = valid_q;
    assign redirect_pc    = pc_q;
    assign flush          = flush_q;
    assign commit_block   = block_q;
    assign event_cause    = cause_q;

`ifdef FLUSH_CTRL_STATS_EN
    flush_ctrl_stats u_stats (
        .clk        (clk),
        .resetn     (resetn),
        .accept     (accept),
        .cause      (ev_cause),
        .exc_count  (exc_count),
        .int_count  (int_count),
        .eret_count (eret_count)
    );
`endif

endmodule
